// File: rtl/spi_frame_pkg.sv
// Shared constants and types for the SPI frame decoder.
// Optional macro SPI_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte to PUSH frames.
package spi_frame_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_PUSH    = 8'h01;
    localparam logic [7:0] CMD_CLR_ERR = 8'h02;
    localparam logic [7:0] CMD_FLUSH   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        COMMIT,
        DISCARD
    } state_t;

    localparam int STAT_FULL  = 7;
    localparam int STAT_EMPTY = 6;
    localparam int STAT_OVF   = 5;
    localparam int STAT_FERR  = 4;

    function automatic logic [3:0] sat_free(input int unsigned free);
        return (free > 15) ? 4'hF : free[3:0];
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// First-word-fall-through segment FIFO with flush and a look-ahead level.
// Pointers carry one extra MSB so full and empty are distinguishable.
module seg_fifo #(
    parameter int Width = 32,
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level,
    output logic [$clog2(Depth):0]   level_nxt
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wptr - rptr;
    assign full    = (level == (AW+1)'(Depth));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else
            level_nxt = level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (flush)
                rptr <= wptr;
            else if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses SPI command frames into segment words and queues them for the step generator.
// Define SPI_FRAME_CHECKSUM_EN to require a trailing XOR checksum on PUSH frames.
module spi_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter int DataBytes = 4,
    parameter int FifoDepth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs,
    input  logic                       word_ready,
    input  logic [7:0]                 rx_byte,
    output logic [7:0]                 tx_byte,
    output logic [8*DataBytes-1:0]     seg_data,
    output logic                       seg_valid,
    input  logic                       seg_ready,
    output logic [$clog2(FifoDepth):0] fifo_level
);

    localparam int W  = 8 * DataBytes;
    localparam int LW = $clog2(FifoDepth) + 1;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   asm_q;
    logic [W-1:0]   asm_nxt;
    logic [7:0]     cnt;
    logic [7:0]     cnt_nxt;
    logic           ovf;
    logic           ovf_nxt;
    logic           ferr;
    logic           ferr_nxt;
    logic           push;
    logic           flush;
    logic           full;
    logic           empty;
    logic [LW-1:0]  level_nxt;
    logic [LW-1:0]  free_slots;
    logic           rx;
    logic           last;
`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0]     csum;
    logic [7:0]     csum_nxt;
`endif

    assign rx   = word_ready & ~cs;
    assign last = (cnt == 8'(DataBytes - 1));

    always_comb begin
        state_nxt = state;
        asm_nxt   = asm_q;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        ferr_nxt  = ferr;
        push      = 1'b0;
        flush     = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
        csum_nxt  = csum;
`endif
        if (cs) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (rx) begin
                    case (rx_byte)
                        CMD_NOP: ;
                        CMD_PUSH: begin
                            state_nxt = PAYLOAD;
                            cnt_nxt   = '0;
`ifdef SPI_FRAME_CHECKSUM_EN
                            csum_nxt  = rx_byte;
`endif
                        end
                        CMD_CLR_ERR: begin
                            ovf_nxt  = 1'b0;
                            ferr_nxt = 1'b0;
                        end
                        CMD_FLUSH: flush = 1'b1;
                        default: begin
                            ferr_nxt  = 1'b1;
                            state_nxt = DISCARD;
                        end
                    endcase
                end
                PAYLOAD: if (rx) begin
                    asm_nxt = W'({asm_q, rx_byte});
                    cnt_nxt = cnt + 8'd1;
`ifdef SPI_FRAME_CHECKSUM_EN
                    csum_nxt = csum ^ rx_byte;
                    if (last)
                        state_nxt = CHECK;
`else
                    if (last)
                        state_nxt = COMMIT;
`endif
                end
`ifdef SPI_FRAME_CHECKSUM_EN
                CHECK: if (rx) begin
                    if (rx_byte == csum) begin
                        state_nxt = COMMIT;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`else
                CHECK: state_nxt = IDLE;
`endif
                COMMIT: begin
                    if (full)
                        ovf_nxt = 1'b1;
                    else
                        push = 1'b1;
                    state_nxt = IDLE;
                end
                DISCARD: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            ferr  <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            asm_q <= asm_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
            ferr  <= ferr_nxt;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum  <= csum_nxt;
`endif
        end
    end

    // Status reflects the state that will hold after this edge.
    assign free_slots = LW'(FifoDepth) - level_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_byte <= 8'h4F;
        else begin
            tx_byte[STAT_FULL]  <= (level_nxt == LW'(FifoDepth));
            tx_byte[STAT_EMPTY] <= (level_nxt == '0);
            tx_byte[STAT_OVF]   <= ovf_nxt;
            tx_byte[STAT_FERR]  <= ferr_nxt;
            tx_byte[3:0]        <= sat_free(32'(free_slots));
        end
    end

    seg_fifo #(
        .Width (W),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (seg_ready),
        .flush     (flush),
        .wdata     (asm_q),
        .rdata     (seg_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level),
        .level_nxt (level_nxt)
    );

    assign seg_valid = ~empty;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: byte-level frame driver, vector table, corner sequences.
// Honors SPI_FRAME_CHECKSUM_EN by appending the XOR checksum byte to complete PUSH frames.
module tb_spi_frame_decoder;

`ifdef SPI_FRAME_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        word_ready;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [31:0] seg_data;
    logic        seg_valid;
    logic        seg_ready;
    logic [4:0]  fifo_level;

    int checks = 0;
    int failures = 0;

    spi_frame_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .word_ready (word_ready),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .seg_data   (seg_data),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] bytes;
        int          n;
        bit          csum;
        int          lvl;
        logic [31:0] data;
        logic        ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte    = b;
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] b, input int n,
                              input bit with_csum);
        logic [7:0] x;
        logic [7:0] v;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            v = b[47-8*k -: 8];
            x = x ^ v;
            send(v);
        end
        if (CsumEn && with_csum)
            send(x);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] seg8;
        logic [7:0] exp_tx;

        vecs[0] = '{name:"nop", bytes:48'h000000000000, n:1, csum:0,
                    lvl:0, data:32'h0, ferr:1'b0};
        vecs[1] = '{name:"push_12345678", bytes:48'h011234567800, n:5,
                    csum:1, lvl:1, data:32'h12345678, ferr:1'b0};
        vecs[2] = '{name:"abort", bytes:48'h011122000000, n:3, csum:0,
                    lvl:0, data:32'h0, ferr:1'b0};
        vecs[3] = '{name:"push_aabbccdd", bytes:48'h01AABBCCDD00, n:5,
                    csum:1, lvl:1, data:32'hAABBCCDD, ferr:1'b0};
        vecs[4] = '{name:"bad_cmd", bytes:48'h7F0100000000, n:6, csum:0,
                    lvl:0, data:32'h0, ferr:1'b1};
        vecs[5] = '{name:"push_after_err", bytes:48'h01CAFE000100, n:5,
                    csum:1, lvl:1, data:32'hCAFE0001, ferr:1'b1};
        vecs[6] = '{name:"clr_err", bytes:48'h020000000000, n:1, csum:0,
                    lvl:0, data:32'h0, ferr:1'b0};
        vecs[7] = '{name:"push_01020304", bytes:48'h010102030400, n:5,
                    csum:1, lvl:1, data:32'h01020304, ferr:1'b0};

        rst        = 1'b1;
        cs         = 1'b1;
        word_ready = 1'b0;
        rx_byte    = 8'h00;
        seg_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", 32'(tx_byte), 32'h4F);
        chk("reset_valid", 32'(seg_valid), 32'h0);
        chk("reset_level", 32'(fifo_level), 32'h0);
        chk("reset_data", seg_data, 32'h0);

        // Latency: last frame byte sampled at edge N, valid after edge N+1.
        cs        = 1'b0;
        seg_ready = 1'b1;
        send_frame(48'h01DEADBEEF00, 5, 1'b1);
        chk("lat_n1_valid", 32'(seg_valid), 32'h0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(seg_valid), 32'h1);
        chk("lat_n2_data", seg_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("lat_pop_level", 32'(fifo_level), 32'h0);
        chk("lat_pop_valid", 32'(seg_valid), 32'h0);

        // Overflow: 17 pushes into 16 entries with the consumer stalled.
        seg_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            seg8 = 8'(i + 1);
            send_frame({8'h01, seg8, seg8, seg8, seg8, 8'h00}, 5, 1'b1);
        end
        @(negedge clk);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_tx", 32'(tx_byte), 32'hA0);
        chk("ovf_head", seg_data, 32'h01010101);
        send(8'h02);
        chk("clr_tx", 32'(tx_byte), 32'h80);
        chk("clr_level", 32'(fifo_level), 32'd16);
        send(8'h03);
        chk("flush_tx", 32'(tx_byte), 32'h4F);
        chk("flush_level", 32'(fifo_level), 32'h0);
        cs = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            cs = 1'b0;
            send_frame(vecs[v].bytes, vecs[v].n, vecs[v].csum);
            repeat (2) @(negedge clk);
            cs = 1'b1;
            repeat (2) @(negedge clk);
            exp_tx = {1'b0, vecs[v].lvl == 0, 1'b0, vecs[v].ferr, 4'hF};
            chk({vecs[v].name, "_level"}, 32'(fifo_level), 32'(vecs[v].lvl));
            chk({vecs[v].name, "_tx"}, 32'(tx_byte), 32'(exp_tx));
            if (vecs[v].lvl != 0) begin
                chk({vecs[v].name, "_data"}, seg_data, vecs[v].data);
                seg_ready = 1'b1;
                @(negedge clk);
                seg_ready = 1'b0;
                chk({vecs[v].name, "_popped"}, 32'(fifo_level), 32'h0);
            end
        end

        if (CsumEn) begin
            @(negedge clk);
            cs = 1'b0;
            send(8'h01);
            send(8'h01);
            send(8'h02);
            send(8'h03);
            send(8'h04);
            send(8'h06);
            repeat (2) @(negedge clk);
            cs = 1'b1;
            repeat (2) @(negedge clk);
            chk("bad_csum_level", 32'(fifo_level), 32'h0);
            chk("bad_csum_tx", 32'(tx_byte), 32'h5F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
Consumes the byte stream produced by the SPI secondary shift stage: word_ready pulse plus received byte. Parses command frames, assembles multi-byte motion-segment words, and buffers them in an internal FIFO for the downstream step generator. Continuously drives the status byte that the SPI stage shifts back to the host.

Parameters:
DataBytes, 4, payload bytes per segment word; segment width = 8*DataBytes
FifoDepth, 16, segment FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cs  in  1  SPI chip select as seen by the SPI stage; high = deselected / frame abort
word_ready  in  1  one-clk pulse: rx_byte valid
rx_byte  in  8  byte just received
tx_byte  out  8  status byte offered to the SPI stage (loaded by it on cs high and on word_ready)
seg_data  out  8*DataBytes  FIFO head segment
seg_valid  out  1  FIFO non-empty
seg_ready  in  1  consumer pops the head when seg_valid && seg_ready
fifo_level  out  $clog2(FifoDepth)+1  current entry count

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, sticky flags 0, seg_valid=0, seg_data=0, fifo_level=0, tx_byte=8'h4F.
- Status byte, registered, recomputed every cycle from post-update state: [7] full, [6] empty, [5] overflow sticky, [4] frame_err sticky, [3:0] free slots saturated at 15.
- Commands (first byte of a frame): 8'h00 NOP; 8'h01 PUSH, followed by DataBytes payload bytes, MSB first; 8'h02 CLR_ERR, clears both sticky flags; 8'h03 FLUSH, empties the FIFO. Any other value sets frame_err and goes to DISCARD.
- FSM states:
  - IDLE: on word_ready, decode. PUSH -> PAYLOAD with byte counter=0. NOP/CLR_ERR/FLUSH act in the next cycle and stay in IDLE.
  - PAYLOAD: each word_ready shifts rx_byte into the assembly register. On the DataBytes-th byte, go to COMMIT (or CHECK with the optional feature).
  - COMMIT: single cycle. Push the assembly register if not full, else drop it and set overflow. -> IDLE.
  - DISCARD: ignore all bytes until cs high.
- cs high in any state: next cycle FSM=IDLE, partial assembly discarded, no push; FIFO and sticky flags kept.
- word_ready while cs high is ignored.
- FIFO:
  - Push and pop in the same cycle: both occur, level unchanged.
  - Push when full: dropped (see COMMIT).
  - Pop when empty: impossible, since seg_valid=0.
  - FLUSH takes priority over a same-cycle pop.
  - Pointers wrap modulo FifoDepth; level uses the extra MSB.
- seg_data is first-word-fall-through: valid in the same cycle as seg_valid.
- Latency: final payload byte's word_ready at cycle N -> seg_valid earliest at N+2 (empty FIFO).

Optional Feature:
SPI_FRAME_CHECKSUM_EN
- Defined: PUSH frames carry one extra trailing byte equal to the XOR of the command byte and all payload bytes. CHECK state compares it. On mismatch, set frame_err, no push, -> IDLE; on match -> COMMIT. Adds one frame byte and one cycle of latency.
- Undefined: no CHECK state; frame length is 1+DataBytes.

Decomposition:
- Package spi_frame_pkg: command byte constants, state enum (IDLE, PAYLOAD, CHECK, COMMIT, DISCARD), status bit index constants.
- Sub-module seg_fifo: parameterised synchronous FWFT FIFO with push, pop, flush, level. Shares clk/rst.

Test Plan:
- Reset, then idle -> tx_byte=8'h4F, seg_valid=0, fifo_level=0.
- cs low; send 01 DE AD BE EF; seg_ready=1 -> seg_valid pulses with seg_data=32'hDEADBEEF; level back to 0.
- seg_ready=0; push 17 segments (depth 16) -> level=16, tx_byte[7]=1, tx_byte[5]=1, 17th dropped; send 02 -> tx_byte[5]=0.
- Send 01 11 22, then raise cs -> no push, FSM=IDLE; next frame 01 AA BB CC DD -> seg_data=32'hAABBCCDD.
- Send 7F then 01 00 00 00 00 in the same cs window -> frame_err=1, no push; after cs toggles, PUSH works again.
- With SPI_FRAME_CHECKSUM_EN: 01 01 02 03 04 05 (XOR=05) -> pushed; checksum 06 -> frame_err=1, no push.
